// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and register file.
// Register index, data word and pending-counter widths live here so all users agree.
package wb_pkg;

    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);
    localparam int DW    = 64;
    localparam int PCW   = 2;

    typedef logic [AW-1:0]  reg_idx_t;
    typedef logic [DW-1:0]  word_t;
    typedef logic [PCW-1:0] pend_cnt_t;

    localparam reg_idx_t  REG_ZERO = '0;
    localparam pend_cnt_t CNT_ONE  = pend_cnt_t'(1);
    localparam pend_cnt_t CNT_MAX  = '1;

    // One read port: r0 is hardwired zero, a same-cycle commit wins over the array.
    function automatic word_t rd_port(input reg_idx_t addr, input logic commit,
                                      input reg_idx_t wr_idx, input word_t wr_val,
                                      input word_t arr_val);
        if (addr == REG_ZERO)
            return '0;
        else if (commit && (wr_idx == addr))
            return wr_val;
        else
            return arr_val;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: per-register saturating counters, RAW/full stall, sticky underflow flag.
// Latency: stall is combinational; counters update on the clock after issue/retire.
// Backpressure: stall blocks issue; a retire to the same register releases it in the retire cycle.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             iss_wb,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic             stall,
    output logic             sb_err
);

    pend_cnt_t cnt [NREGS];
    logic      inc;
    logic      dec;
    logic      hz1;
    logic      hz2;
    logic      full;

    always_comb begin
        dec   = wb_valid & wb_en & (wb_rd != REG_ZERO);
        hz1   = (rs1_addr != REG_ZERO) && (cnt[rs1_addr] != '0) &&
                !(dec && (wb_rd == rs1_addr) && (cnt[rs1_addr] == CNT_ONE));
        hz2   = (rs2_addr != REG_ZERO) && (cnt[rs2_addr] != '0) &&
                !(dec && (wb_rd == rs2_addr) && (cnt[rs2_addr] == CNT_ONE));
        full  = iss_valid && iss_wb && (cnt[iss_rd] == CNT_MAX) &&
                !(dec && (wb_rd == iss_rd));
        stall = hz1 | hz2 | full;
        inc   = iss_valid & ~stall & iss_wb & (iss_rd != REG_ZERO);
    end

    assign cnt[0] = '0;

    for (genvar k = 1; k < NREGS; k++) begin : g_cnt
        logic inc_k;
        logic dec_k;
        assign inc_k = inc && (iss_rd == reg_idx_t'(k));
        assign dec_k = dec && (wb_rd == reg_idx_t'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt[k] <= '0;
            else if (inc_k && !dec_k)
                cnt[k] <= cnt[k] + CNT_ONE;
            else if (dec_k && !inc_k && (cnt[k] != '0))
                cnt[k] <= cnt[k] - CNT_ONE;
        end
    end

    // Underflow: a retire with nothing pending and no same-register issue to cancel it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (dec && !(inc && (iss_rd == wb_rd)) && (cnt[wb_rd] == '0))
            sb_err <= 1'b1;
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback commit into a 16x64 register file with two bypassed read ports and RAW scoreboard.
// Latency: commit lands one clock after wb_valid, visible same cycle via bypass; stall is combinational.
// Backpressure: stall holds operand fetch; WB_RETIRE_CNT_EN adds the retire_cnt output.
module writeback_regfile
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [DW-1:0]    wb_value,
    input  logic [AW-1:0]    wb_rd,
    input  logic             wb_en,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             iss_wb,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [DW-1:0]    rs1_data,
    output logic [DW-1:0]    rs2_data,
    output logic             stall,
    output logic             sb_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]      retire_cnt
`endif
);

    word_t regs [NREGS];
    logic  commit;

    assign commit = wb_valid & wb_en & (wb_rd != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[wb_rd] <= wb_value;
        end
    end

    always_comb begin
        rs1_data = rd_port(rs1_addr, commit, wb_rd, wb_value, regs[rs1_addr]);
        rs2_data = rd_port(rs2_addr, commit, wb_rd, wb_value, regs[rs2_addr]);
    end

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_wb    (iss_wb),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .stall     (stall),
        .sb_err    (sb_err)
    );

`ifdef WB_RETIRE_CNT_EN
    // Counts every retiring slot, including those that write no register; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (wb_valid)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed test-plan sequence, then randomized traffic vs a reference model.
module tb_writeback_regfile;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid, wb_en, iss_valid, iss_wb;
    logic [63:0] wb_value;
    logic [3:0]  wb_rd, iss_rd, rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        stall, sb_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_value(wb_value), .wb_rd(wb_rd), .wb_en(wb_en),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wb(iss_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .sb_err(sb_err)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays of values and integer pending counts.
    logic [63:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err;
    int unsigned m_rc;

    function automatic bit m_commit();
        return wb_valid && wb_en && (wb_rd != 4'd0);
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 64'd0;
        if (m_commit() && wb_rd == a) return wb_value;
        return m_regs[a];
    endfunction

    function automatic bit m_hazard(input logic [3:0] a);
        if (a == 4'd0 || m_cnt[a] == 0) return 1'b0;
        // The retiring instruction is the last pending writer: bypass supplies it.
        if (m_commit() && wb_rd == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = iss_valid && iss_wb && (m_cnt[iss_rd] == 3) && !(m_commit() && wb_rd == iss_rd);
        return m_hazard(rs1_addr) || m_hazard(rs2_addr) || full;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 64'd0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
        m_rc  = 0;
    endtask

    always @(posedge clk) begin : model_update
        bit st, inc, dec;
        if (rst_n) begin
            st  = m_stall();
            inc = iss_valid && !st && iss_wb && (iss_rd != 4'd0);
            dec = m_commit();
            if (dec) m_regs[wb_rd] = wb_value;
            if (!(inc && dec && iss_rd == wb_rd)) begin
                if (inc) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
                if (dec) begin
                    if (m_cnt[wb_rd] == 0) m_err = 1'b1;
                    else m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
                end
            end
            if (wb_valid) m_rc = m_rc + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cmp_rs1_data", rs1_data, m_read(rs1_addr));
            chk("cmp_rs2_data", rs2_data, m_read(rs2_addr));
            chk("cmp_stall", {63'd0, stall}, {63'd0, m_stall()});
            chk("cmp_sb_err", {63'd0, sb_err}, {63'd0, m_err});
`ifdef WB_RETIRE_CNT_EN
            chk("cmp_retire_cnt", {32'd0, retire_cnt}, {32'd0, m_rc});
`endif
        end
    end

    task automatic idle();
        wb_valid = 0; wb_en = 0; wb_rd = 0; wb_value = 0;
        iss_valid = 0; iss_wb = 0; iss_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        next();
        next();
        rst_n = 1'b1;
    endtask

    task automatic retire(input logic [3:0] rd, input logic en, input logic [63:0] v);
        wb_valid = 1; wb_en = en; wb_rd = rd; wb_value = v;
    endtask

    task automatic issue(input logic [3:0] rd);
        iss_valid = 1; iss_wb = 1; iss_rd = rd;
    endtask

    initial begin
        int pend[$];
        idle();
        model_clear();
        next();
        do_reset();
        checking = 1'b1;

        // Reset read-back
        idle(); rs1_addr = 3; rs2_addr = 0; #3;
        chk("rst_rs1_data", rs1_data, 64'd0);
        chk("rst_rs2_data", rs2_data, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        next();

        // RAW hazard on r5 and retire-cycle release
        idle(); issue(5); #3;
        chk("iss5_stall", {63'd0, stall}, 64'd0);
        next();
        idle(); rs1_addr = 5; #3;
        chk("raw5_stall", {63'd0, stall}, 64'd1);
        next();
        idle(); rs1_addr = 5; retire(5, 1, 64'h9); #3;
        chk("rel5_stall", {63'd0, stall}, 64'd0);
        chk("byp5_data", rs1_data, 64'h9);
        next();
        idle(); rs1_addr = 5; #3;
        chk("reg5_data", rs1_data, 64'h9);
        chk("model_reg5", m_regs[5], 64'h9);
        next();

        // r0 write discarded, no error
        idle(); rs1_addr = 0; retire(0, 1, 64'hFFFF); #3;
        chk("r0_read", rs1_data, 64'd0);
        next();
        idle(); #3;
        chk("r0_noerr", {63'd0, sb_err}, 64'd0);
        next();

        // Saturate r7 and release full with a same-cycle retire
        for (int i = 0; i < 3; i++) begin
            idle(); issue(7); #3;
            chk("r7_issue_stall", {63'd0, stall}, 64'd0);
            next();
        end
        chk("model_cnt7", m_cnt[7], 64'd3);
        idle(); issue(7); #3;
        chk("full_stall", {63'd0, stall}, 64'd1);
        retire(7, 1, 64'h77); #1;
        chk("full_release", {63'd0, stall}, 64'd0);
        next();
        chk("model_cnt7_hold", m_cnt[7], 64'd3);
        idle(); issue(7); #3;
        chk("still_full", {63'd0, stall}, 64'd1);
        next();

        // Underflow on r4, sticky, cleared by async reset mid-cycle
        idle(); retire(4, 1, 64'h44); #3;
        next();
        idle(); #3;
        chk("sb_err_set", {63'd0, sb_err}, 64'd1);
        next();
        idle(); #3;
        chk("sb_err_sticky", {63'd0, sb_err}, 64'd1);
        next();
        idle(); rs1_addr = 5; #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_sb_err", {63'd0, sb_err}, 64'd0);
        chk("arst_reg5", rs1_data, 64'd0);
        rs1_addr = 7; #1;
        chk("arst_stall", {63'd0, stall}, 64'd0);
        next();
        rst_n = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); retire(4'(i + 1), (i != 1 && i != 3), 64'(i)); #3;
            next();
        end
        idle(); #3;
        chk("retire_cnt_5", {32'd0, retire_cnt}, 64'd5);
        next();
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            idle();
            rs1_addr = 4'($urandom_range(15));
            rs2_addr = 4'($urandom_range(15));
            if ($urandom_range(1) == 1) begin
                iss_valid = 1;
                iss_wb    = ($urandom_range(4) != 0);
                iss_rd    = 4'($urandom_range(15));
            end
            if ($urandom_range(1) == 1) begin
                pend.delete();
                for (int k = 1; k < 16; k++)
                    if (m_cnt[k] > 0) pend.push_back(k);
                wb_valid = 1;
                wb_en    = ($urandom_range(6) != 0);
                wb_value = {$urandom, $urandom};
                if (pend.size() > 0 && $urandom_range(19) != 0)
                    wb_rd = 4'(pend[$urandom_range(pend.size() - 1)]);
                else
                    wb_rd = 4'($urandom_range(15));
            end
            next();
        end

        checking = 1'b0;
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage plus architectural register file. It sits directly downstream of the memory-access stage and consumes that stage's registered 64-bit result.
- It commits results into a 16x64 register file and serves two combinational read ports to operand fetch (OF), with same-cycle write bypass.
- A per-register pending-write scoreboard generates the OF stall signal for RAW hazards.

Parameters:
- NREGS, 16: number of architectural registers; r0 is hardwired to zero.
- AW, 4: register index width, equal to clog2(NREGS).
- DW, 64: data width; must match the memory-access output width.
- PCW, 2: width of the per-register pending counter; saturates at 2^PCW-1.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  retiring instruction present; aligned with wb_value (memory-access output cycle).
- wb_value  in  DW  result from the memory-access stage.
- wb_rd  in  AW  destination register.
- wb_en  in  1  instruction writes a register.
- iss_valid  in  1  OF issues an instruction this cycle (ignored when stall=1).
- iss_rd  in  AW  destination of the issuing instruction.
- iss_wb  in  1  issuing instruction will write iss_rd.
- rs1_addr  in  AW  read port 1 index.
- rs2_addr  in  AW  read port 2 index.
- rs1_data  out  DW  read port 1 data.
- rs2_data  out  DW  read port 2 data.
- stall  out  1  OF must hold; issue is blocked.
- sb_err  out  1  sticky: a retire occurred against a zero pending count.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - All registers clear to 0.
  - All pending counters clear to 0.
  - sb_err clears to 0.
  - rs*_data read 0; stall reads 0.
- Commit:
  - Condition: wb_valid & wb_en & (wb_rd != 0).
  - regs[wb_rd] <= wb_value on posedge clk.
  - Writes to r0 are discarded.
- Reads (combinational):
  - rsN_data = 0 if rsN_addr == 0.
  - Otherwise wb_value if commit is active this cycle and wb_rd == rsN_addr (bypass).
  - Otherwise regs[rsN_addr].
- Scoreboard (one PCW-bit counter per register; r0 counter always 0):
  - inc = iss_valid & ~stall & iss_wb & (iss_rd != 0).
  - dec = wb_valid & wb_en & (wb_rd != 0).
  - inc only on register k: cnt[k] + 1.
  - dec only on register k: cnt[k] - 1.
  - inc and dec on the same register: unchanged.
  - inc and dec on different registers: both applied.
  - dec with cnt == 0 and no simultaneous inc: counter stays 0; sb_err <= 1 (sticky until reset).
- Stall (combinational):
  - stall = hz1 | hz2 | full.
  - hzN = (rsN_addr != 0) & (cnt[rsN_addr] != 0) & ~(dec & wb_rd == rsN_addr & cnt[rsN_addr] == 1).
    - This is a retire-cycle release: the bypass supplies the value in that cycle.
  - full = iss_valid & iss_wb & (cnt[iss_rd] == max) & ~(dec & wb_rd == iss_rd).
  - A stalled issue causes no scoreboard change.
- Latency:
  - Commit is visible in regs one cycle after wb_valid.
  - The same-cycle value is visible via the bypass.
  - Stall release is in the retire cycle.
- Reset mid-operation: all in-flight pending state is lost; upstream stages must flush in the same reset.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt (out, 32).
  - It counts cycles with wb_valid=1, including wb_en=0 retires.
  - Resets to 0 and wraps 0xFFFFFFFF -> 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - constants NREGS, AW, DW, PCW, REG_ZERO = 0;
  - typedef reg_idx_t (AW bits);
  - typedef word_t (DW bits);
  - typedef pend_cnt_t (PCW bits).
- One sub-module, wb_scoreboard, owns the counters, the stall logic and sb_err.
- The top level owns the register array, the read/bypass muxes and the optional counter.

Test Plan:
- Reset then read: rs1=3, rs2=0 -> rs1_data=0, rs2_data=0, stall=0.
- Issue r5 (iss_valid=1, iss_wb=1); next cycle rs1=5 -> stall=1. Retire wb_rd=5, value 0x9 -> same cycle stall=0, rs1_data=0x9; next cycle regs[5]=0x9.
- Commit to r0 with value 0xFFFF -> rs1=0 still reads 0; no sb_err.
- Issue r7 three times with no retire -> cnt=3. Fourth issue -> stall=1 (full). Retire r7 in the same cycle -> stall=0 and cnt remains 3.
- Retire r4 with cnt[4]=0 -> sb_err=1 and it persists; assert rst_n=0 mid-cycle -> sb_err, regs and counters are 0 immediately.
- With WB_RETIRE_CNT_EN defined: 5 wb_valid cycles, 2 of them with wb_en=0 -> retire_cnt=5.
